tx_pattern_gen: RTL and testbench

TX_PATTERN_GEN -- requirements
Module: tx_pattern_gen

---
 rtl/tx_pattern_gen.sv | 146 ++++++++++++++
 tb/tb_tx_pattern_gen.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_pattern_gen.sv
// rtl/tx_pattern_gen.sv - multi-lane PRBS/fixed pattern source with error injection and driver strength ramp
// PRBS7/15/31 Fibonacci LFSR unrolled N_LANES bits per clk; thermometer driver codes ramp one step per tick.
module tx_pattern_gen #(
  parameter int N_LANES  = 16,
  parameter int N_DRV    = 40,
  parameter int N_CODE   = 6,
  parameter int RAMP_DIV = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cke,
  input  logic [1:0]         mode,
  input  logic [N_LANES-1:0] fixed_pat,
  input  logic               inj_err,
  input  logic               inv,
  input  logic [N_CODE-1:0]  code_n,
  input  logic [N_CODE-1:0]  code_p,
  output logic [N_LANES-1:0] dout,
  output logic [N_DRV-1:0]   ctl_n,
  output logic [N_DRV-1:0]   ctl_p,
  output logic               ramp_busy,
  output logic [15:0]        err_cnt
);

  localparam int                CW       = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
  localparam logic [CW-1:0]     CNT_MAX  = CW'(RAMP_DIV - 1);
  localparam logic [N_CODE-1:0] DRV_MAX  = N_CODE'(N_DRV);
  localparam logic [1:0]        MODE_FIX = 2'd3;

  logic [30:0]        lfsr_q, lfsr_d;
  logic [1:0]         mode_q;
  logic [N_LANES-1:0] dout_q, dout_d;
  logic [15:0]        err_q, err_d;
  logic               inj_q1, inj_q2;
  logic               armed_q, armed_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [N_CODE-1:0]  cur_n_q, cur_n_d, cur_p_q, cur_p_d;
  logic [N_DRV-1:0]   ctl_n_q, ctl_p_q;

  logic [30:0]        mask, seed, s;
  logic               fb;
  logic [N_LANES-1:0] prbs_word, word;
  logic               rise, pend, tick;
  logic [N_CODE-1:0]  tgt_n, tgt_p;

  function automatic logic [N_DRV-1:0] thermo(input logic [N_CODE-1:0] c);
    logic [N_DRV-1:0] t;
    t = '0;
    for (int k = 0; k < N_DRV; k++) t[k] = (N_CODE'(k) < c);
    return t;
  endfunction

  function automatic logic [N_CODE-1:0] ramp_step(input logic [N_CODE-1:0] cur,
                                                  input logic [N_CODE-1:0] tgt);
    if (cur < tgt)      return cur + N_CODE'(1);
    else if (cur > tgt) return cur - N_CODE'(1);
    else                return cur;
  endfunction

  // Only the active L bits matter; a mode change or a zero state restarts from all-ones.
  always_comb begin
    case (mode)
      2'd0:    mask = 31'h0000_007F;
      2'd1:    mask = 31'h0000_7FFF;
      default: mask = 31'h7FFF_FFFF;
    endcase
    seed = lfsr_q;
    if ((mode != mode_q) || ((lfsr_q & mask) == 31'd0)) seed = mask;
    s         = seed;
    fb        = 1'b0;
    prbs_word = '0;
    for (int i = 0; i < N_LANES; i++) begin
      case (mode)
        2'd0:    fb = s[6] ^ s[5];
        2'd1:    fb = s[14] ^ s[13];
        default: fb = s[30] ^ s[27];
      endcase
      prbs_word[i] = fb;
      s = {s[29:0], fb} & mask;
    end
  end

  always_comb begin
    rise    = inj_q1 & ~inj_q2;
    pend    = armed_q | rise;
    word    = (mode == MODE_FIX) ? fixed_pat : prbs_word;
    lfsr_d  = seed;
    dout_d  = dout_q;
    armed_d = pend;
    err_d   = err_q;
    if (cke) begin
      if (mode != MODE_FIX) lfsr_d = s;
      word[0] = word[0] ^ pend;
      dout_d  = word ^ {N_LANES{inv}};
      armed_d = 1'b0;
      if (pend && (err_q != 16'hFFFF)) err_d = err_q + 16'd1;
    end
  end

  always_comb begin
    tick    = (cnt_q == CNT_MAX);
    cnt_d   = tick ? '0 : cnt_q + CW'(1);
    tgt_n   = (code_n > DRV_MAX) ? DRV_MAX : code_n;
    tgt_p   = (code_p > DRV_MAX) ? DRV_MAX : code_p;
    cur_n_d = tick ? ramp_step(cur_n_q, tgt_n) : cur_n_q;
    cur_p_d = tick ? ramp_step(cur_p_q, tgt_p) : cur_p_q;
  end

  // ctl is registered from the next code so it always matches the current code and ramp_busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q  <= '1;
      mode_q  <= 2'd0;
      dout_q  <= '0;
      err_q   <= 16'd0;
      inj_q1  <= 1'b0;
      inj_q2  <= 1'b0;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      cur_n_q <= '0;
      cur_p_q <= '0;
      ctl_n_q <= '0;
      ctl_p_q <= '0;
    end else begin
      lfsr_q  <= lfsr_d;
      mode_q  <= mode;
      dout_q  <= dout_d;
      err_q   <= err_d;
      inj_q1  <= inj_err;
      inj_q2  <= inj_q1;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      cur_n_q <= cur_n_d;
      cur_p_q <= cur_p_d;
      ctl_n_q <= thermo(cur_n_d);
      ctl_p_q <= thermo(cur_p_d);
    end
  end

  assign dout      = dout_q;
  assign err_cnt   = err_q;
  assign ctl_n     = ctl_n_q;
  assign ctl_p     = ctl_p_q;
  assign ramp_busy = (cur_n_q != tgt_n) || (cur_p_q != tgt_p);

endmodule

// File: tb/tb_tx_pattern_gen.sv
// tb/tb_tx_pattern_gen.sv - self-checking bench for tx_pattern_gen
// Reference model: PRBS as the recurrence b[n] = b[n-L] ^ b[n-T] over a bit history.
module tb_tx_pattern_gen;
  localparam int NL = 16;
  localparam int ND = 40;
  localparam int NC = 6;
  localparam int RD = 4;

  logic          clk = 1'b0;
  logic          rst_n, cke, inj_err, inv;
  logic [1:0]    mode;
  logic [NL-1:0] fixed_pat;
  logic [NC-1:0] code_n, code_p;
  logic [NL-1:0] dout;
  logic [ND-1:0] ctl_n, ctl_p;
  logic          ramp_busy;
  logic [15:0]   err_cnt;

  tx_pattern_gen #(.N_LANES(NL), .N_DRV(ND), .N_CODE(NC), .RAMP_DIV(RD)) dut (
    .clk(clk), .rst_n(rst_n), .cke(cke), .mode(mode), .fixed_pat(fixed_pat),
    .inj_err(inj_err), .inv(inv), .code_n(code_n), .code_p(code_p),
    .dout(dout), .ctl_n(ctl_n), .ctl_p(ctl_p), .ramp_busy(ramp_busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          hist[$];
  int          m_l, m_t, cyc, e_cur_n, e_cur_p;
  logic [1:0]  prev_mode;
  bit          s1, s2, armed;
  logic [15:0] e_dout, e_err, golden;

  typedef struct { logic [1:0] mode; logic cke; logic inv; logic [15:0] pat; logic [15:0] exp; } vec_t;
  typedef struct { int k; logic [39:0] ctl; logic busy; } rchk_t;
  vec_t  vt[11];
  rchk_t rc[11];
  bit    pbits[65536];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [39:0] therm(input int c);
    logic [40:0] t;
    t = (41'd1 << c) - 41'd1;
    return t[39:0];
  endfunction

  function automatic int clampc(input logic [NC-1:0] c);
    return (int'(c) > ND) ? ND : int'(c);
  endfunction

  task automatic seq_restart(input logic [1:0] m);
    case (m)
      2'd0:    begin m_l = 7;  m_t = 6;  end
      2'd1:    begin m_l = 15; m_t = 14; end
      default: begin m_l = 31; m_t = 28; end
    endcase
    hist.delete();
    for (int i = 0; i < m_l; i++) hist.push_back(1'b1);
  endtask

  task automatic next_bit(output bit b);
    b = hist[hist.size() - m_l] ^ hist[hist.size() - m_t];
    hist.push_back(b);
    while (hist.size() > 40) void'(hist.pop_front());
  endtask

  task automatic model_reset();
    cyc = 0; e_cur_n = 0; e_cur_p = 0;
    s1 = 0; s2 = 0; armed = 0;
    prev_mode = 2'd0; seq_restart(2'd0);
    e_dout = 16'h0; e_err = 16'h0; golden = 16'h0;
  endtask

  task automatic model_edge();
    int tn, tp; bit tk, rise, pend, b; logic [15:0] w;
    tk = (cyc % RD) == (RD - 1);
    cyc++;
    tn = clampc(code_n); tp = clampc(code_p);
    if (tk) begin
      e_cur_n += (e_cur_n < tn) ? 1 : ((e_cur_n > tn) ? -1 : 0);
      e_cur_p += (e_cur_p < tp) ? 1 : ((e_cur_p > tp) ? -1 : 0);
    end
    rise = s1 && !s2; pend = armed || rise;
    s2 = s1; s1 = inj_err;
    if (mode != prev_mode) seq_restart(mode);
    prev_mode = mode;
    if (cke) begin
      if (mode == 2'd3) w = fixed_pat;
      else for (int i = 0; i < NL; i++) begin next_bit(b); w[i] = b; end
      golden = w ^ {16{inv}};
      if (pend) begin
        w[0] = ~w[0];
        if (e_err != 16'hFFFF) e_err = e_err + 16'd1;
      end
      armed = 0;
      e_dout = w ^ {16{inv}};
    end else begin
      armed = pend;
    end
  endtask

  task automatic check_all();
    logic exp_busy;
    exp_busy = (e_cur_n != clampc(code_n)) || (e_cur_p != clampc(code_p));
    check("dout", 64'(dout), 64'(e_dout));
    check("err_cnt", 64'(err_cnt), 64'(e_err));
    check("ctl_n", 64'(ctl_n), 64'(therm(e_cur_n)));
    check("ctl_p", 64'(ctl_p), 64'(therm(e_cur_p)));
    check("ramp_busy", 64'(ramp_busy), 64'(exp_busy));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk); #1;
    check_all();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; #1;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic prbs_period(input logic [1:0] m, input int per, input int maxz, input string nm);
    int mism, ones, run, maxrun, sub;
    do_reset();
    mode = m; cke = 1'b1;
    for (int w = 0; w < (2 * per + NL) / NL; w++) begin
      step();
      for (int i = 0; i < NL; i++) pbits[w * NL + i] = dout[i];
    end
    mism = 0; ones = 0; run = 0; maxrun = 0;
    for (int n = 0; n < per; n++) begin
      if (pbits[n] != pbits[n + per]) mism++;
      ones += int'(pbits[n]);
      run = pbits[n] ? 0 : run + 1;
      if (run > maxrun) maxrun = run;
    end
    check({nm, "_period"}, 64'(mism), 64'd0);
    check({nm, "_ones"}, 64'(ones), 64'((per + 1) / 2));
    check({nm, "_max_zero_run"}, 64'(maxrun), 64'(maxz));
    sub = 0;
    for (int n = 0; n < per; n++) if (pbits[n] != pbits[n + 1]) sub++;
    check({nm, "_not_constant"}, 64'(sub != 0), 64'd1);
  endtask

  initial begin
    int diffs, hits; logic [15:0] dmask;
    rst_n = 1'b1; cke = 1'b0; mode = 2'd0; inj_err = 1'b0; inv = 1'b0;
    fixed_pat = '0; code_n = '0; code_p = '0;

    vt[0]  = '{2'd3, 1'b1, 1'b0, 16'hA5A5, 16'hA5A5};
    vt[1]  = '{2'd3, 1'b1, 1'b1, 16'hA5A5, 16'h5A5A};
    vt[2]  = '{2'd3, 1'b0, 1'b0, 16'h1234, 16'h5A5A};
    vt[3]  = '{2'd3, 1'b1, 1'b0, 16'h1234, 16'h1234};
    vt[4]  = '{2'd3, 1'b1, 1'b1, 16'hFFFF, 16'h0000};
    vt[5]  = '{2'd0, 1'b1, 1'b0, 16'h0000, 16'h3040};
    vt[6]  = '{2'd0, 1'b1, 1'b0, 16'h0000, 16'h4F14};
    vt[7]  = '{2'd2, 1'b0, 1'b0, 16'h0000, 16'h4F14};
    vt[8]  = '{2'd0, 1'b1, 1'b0, 16'h0000, 16'h3040};
    vt[9]  = '{2'd1, 1'b1, 1'b0, 16'h0000, 16'h4000};
    vt[10] = '{2'd2, 1'b1, 1'b1, 16'h0000, 16'hFFFF};

    rc[0]  = '{3,  40'h0,  1'b1};
    rc[1]  = '{4,  40'h1,  1'b1};
    rc[2]  = '{8,  40'h3,  1'b1};
    rc[3]  = '{12, 40'h7,  1'b1};
    rc[4]  = '{16, 40'hF,  1'b1};
    rc[5]  = '{19, 40'hF,  1'b1};
    rc[6]  = '{20, 40'h1F, 1'b0};
    rc[7]  = '{24, 40'hF,  1'b1};
    rc[8]  = '{28, 40'h7,  1'b1};
    rc[9]  = '{31, 40'h7,  1'b1};
    rc[10] = '{32, 40'h3,  1'b0};

    #2;
    rst_n = 1'b0; #1;
    check("reset_dout", 64'(dout), 64'd0);
    check("reset_ctl_n", 64'(ctl_n), 64'd0);
    check("reset_ctl_p", 64'(ctl_p), 64'd0);
    check("reset_err_cnt", 64'(err_cnt), 64'd0);
    do_reset();

    mode = 2'd0; cke = 1'b1;
    step();
    check("first_word_prbs7", 64'(dout), 64'h3040);

    do_reset();
    for (int r = 0; r < 11; r++) begin
      mode = vt[r].mode; cke = vt[r].cke; inv = vt[r].inv; fixed_pat = vt[r].pat;
      step();
      check($sformatf("table_row%0d", r), 64'(dout), 64'(vt[r].exp));
    end
    inv = 1'b0;

    do_reset();
    mode = 2'd0; cke = 1'b1; diffs = 0; dmask = '0;
    for (int c = 0; c < 20; c++) begin
      inj_err = (c >= 3 && c < 13);
      step();
      if (dout != golden) begin diffs++; dmask |= dout ^ golden; end
    end
    inj_err = 1'b0;
    check("inj_words_hit", 64'(diffs), 64'd1);
    check("inj_bit_mask", 64'(dmask), 64'h1);
    check("inj_err_cnt", 64'(err_cnt), 64'd1);

    do_reset();
    mode = 2'd3; inv = 1'b1; fixed_pat = 16'hA5A5; cke = 1'b1; hits = 0;
    for (int c = 0; c < 12; c++) begin
      inj_err = (c >= 2 && c < 6);
      step();
      if (dout == 16'h5A5B) hits++;
    end
    inj_err = 1'b0; inv = 1'b0;
    check("inv_inj_once", 64'(hits), 64'd1);
    check("inv_fixed_after", 64'(dout), 64'h5A5A);

    do_reset();
    code_n = 6'd5; mode = 2'd0; cke = 1'b0;
    for (int k = 1, j = 0; k <= 32; k++) begin
      if (k == 21) code_n = 6'd2;
      step();
      if (j < 11 && rc[j].k == k) begin
        check($sformatf("ramp_ctl_n_k%0d", k), 64'(ctl_n), 64'(rc[j].ctl));
        check($sformatf("ramp_busy_k%0d", k), 64'(ramp_busy), 64'(rc[j].busy));
        j++;
      end
    end

    do_reset();
    code_n = 6'd0; code_p = 6'd63;
    for (int k = 0; k < 4 * ND + 8; k++) step();
    check("sat_ctl_p", 64'(ctl_p), 64'hFF_FFFF_FFFF);
    check("sat_busy", 64'(ramp_busy), 64'd0);
    code_p = 6'd0;
    for (int k = 0; k < 10; k++) step();
    #2 rst_n = 1'b0; #1;
    check("midramp_rst_dout", 64'(dout), 64'd0);
    check("midramp_rst_ctl_p", 64'(ctl_p), 64'd0);
    check("midramp_rst_ctl_n", 64'(ctl_n), 64'd0);
    check("midramp_rst_busy", 64'(ramp_busy), 64'd0);
    check("midramp_rst_err", 64'(err_cnt), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();

    prbs_period(2'd0, 127, 6, "prbs7");
    prbs_period(2'd1, 32767, 14, "prbs15");

    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(39, 0) == 0) mode = 2'($urandom_range(3, 0));
      cke = ($urandom_range(3, 0) != 0);
      if ($urandom_range(5, 0) == 0) inj_err = ~inj_err;
      if ($urandom_range(19, 0) == 0) inv = ~inv;
      fixed_pat = 16'($urandom);
      if ($urandom_range(29, 0) == 0) code_n = 6'($urandom_range(63, 0));
      if ($urandom_range(29, 0) == 0) code_p = 6'($urandom_range(63, 0));
      if (c == 1500) do_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
